// File: rtl/controlador_contador_compartido_pkg.sv
// Shared types, defaults and reference arithmetic for the
// shared-counter round-robin controller.
package controlador_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int WIDTH_DEF = 4;
  localparam int LEN_W_DEF = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    COUNT = 3'd2,
    READ  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Value the counter holds after loading lv and counting len cycles.
  function automatic logic [31:0] exp_result(
    input logic [31:0] lv,
    input logic [31:0] len,
    input int          w
  );
    logic [31:0] mask;
    mask = (32'd1 << w) - 32'd1;
    return (lv + len) & mask;
  endfunction

endpackage

// File: rtl/controlador_contador_compartido_if.sv
// Requester-side bundle: request fields in, grant/done/result out.
// master = requesters, slave = controller.
interface controlador_contador_compartido_if
  import controlador_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int LEN_W = LEN_W_DEF
);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] load_val;
  logic [N_REQ*LEN_W-1:0] cnt_len;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       done;
  logic [WIDTH-1:0]       result;
  logic                   busy;

  modport master (
    output req,
    output load_val,
    output cnt_len,
    input  gnt,
    input  done,
    input  result,
    input  busy
  );

  modport slave (
    input  req,
    input  load_val,
    input  cnt_len,
    output gnt,
    output done,
    output result,
    output busy
  );

endinterface

// File: rtl/controlador_contador_compartido_arbitro_rr.sv
// Combinational round-robin pick: first set req bit at or after ptr,
// wrapping modulo N_REQ.
module arbitro_rr
  import controlador_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt_oh,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!any && req[(int'(ptr) + k) % N_REQ]) begin
        any     = 1'b1;
        gnt_idx = IDX_W'((int'(ptr) + k) % N_REQ);
        gnt_oh[(int'(ptr) + k) % N_REQ] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/controlador_contador_compartido.sv
// Round-robin owner of one shared loadable counter: load, count,
// read back over the tri-state bus, and report to the winner.
module controlador_contador_compartido
  import controlador_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  controlador_contador_compartido_if.slave bus,
  output logic             cnt_load,
  output logic             cnt_en,
  output logic             cnt_oe,
  output logic [WIDTH-1:0] cnt_d,
  input  logic [WIDTH-1:0] cnt_q
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef logic [IDX_W-1:0] idx_t;

  state_t           state_q, state_d;
  idx_t             idx_q, idx_d;
  idx_t             ptr_q, ptr_d;
  idx_t             arb_idx;
  logic [N_REQ-1:0] arb_oh;
  logic             arb_any;
  logic             win_req;
  logic [LEN_W-1:0] down_q, down_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] lv_q, lv_d;
  logic [LEN_W-1:0] len_q, len_d;

  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic             busy_q, busy_d;
  logic             load_q, load_d;
  logic             en_q, en_d;
  logic             oe_q, oe_d;
  logic [WIDTH-1:0] d_q, d_d;

  function automatic idx_t nxt(input idx_t i);
    return (int'(i) == N_REQ - 1) ? '0 : idx_t'(int'(i) + 1);
  endfunction

  arbitro_rr #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req     (bus.req),
    .ptr     (ptr_q),
    .gnt_oh  (arb_oh),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    ptr_d    = ptr_q;
    down_d   = down_q;
    result_d = result_q;
    lv_d     = lv_q;
    len_d    = len_q;
    win_req  = bus.req[idx_q];
    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          state_d = LOAD;
          idx_d   = arb_idx;
          down_d  = bus.cnt_len[int'(arb_idx)*LEN_W +: LEN_W];
          len_d   = bus.cnt_len[int'(arb_idx)*LEN_W +: LEN_W];
          lv_d    = bus.load_val[int'(arb_idx)*WIDTH +: WIDTH];
        end
      end
      LOAD: begin
        if (!win_req) begin
          state_d = IDLE;
          ptr_d   = nxt(idx_q);
        end else if (down_q == '0) begin
          state_d = READ;
        end else begin
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (!win_req) begin
          state_d = IDLE;
          ptr_d   = nxt(idx_q);
        end else if (down_q == LEN_W'(1)) begin
          state_d = READ;
        end else begin
          down_d = down_q - LEN_W'(1);
        end
      end
      READ: begin
        state_d  = DONE;
        result_d = cnt_q;
        ptr_d    = nxt(idx_q);
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so no
  // input reaches a pin without passing a flop.
  always_comb begin
    gnt_d  = '0;
    done_d = '0;
    d_d    = '0;
    busy_d = (state_d != IDLE);
    load_d = (state_d == LOAD);
    en_d   = (state_d == COUNT);
    oe_d   = (state_d == READ);
    if (state_d != IDLE) begin
      gnt_d = (state_q == IDLE) ? arb_oh : gnt_q;
    end
    if (state_d == DONE) begin
      done_d = gnt_q;
    end
    if (state_d == LOAD) begin
      d_d = bus.load_val[int'(idx_d)*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      ptr_q    <= '0;
      down_q   <= '0;
      result_q <= '0;
      lv_q     <= '0;
      len_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      load_q   <= 1'b0;
      en_q     <= 1'b0;
      oe_q     <= 1'b0;
      d_q      <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      ptr_q    <= ptr_d;
      down_q   <= down_d;
      result_q <= result_d;
      lv_q     <= lv_d;
      len_q    <= len_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      load_q   <= load_d;
      en_q     <= en_d;
      oe_q     <= oe_d;
      d_q      <= d_d;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;
  assign bus.result = result_q;
  assign cnt_load   = load_q;
  assign cnt_en     = en_q;
  assign cnt_oe     = oe_q;
  assign cnt_d      = d_q;

  a_load_en_excl: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(cnt_load && cnt_en)
  );

  a_oe_only_read: assert property (
    @(posedge clk) disable iff (!rst_n)
    cnt_oe |-> (state_q == READ)
  );

  a_result_ok: assert property (
    @(posedge clk) disable iff (!rst_n)
    (state_q == DONE) |->
      (32'(result_q) == exp_result(32'(lv_q), 32'(len_q), WIDTH))
  );

endmodule

// File: doc/controlador_contador_compartido.md
# controlador_contador_compartido

Round-robin controller that shares one loadable up-counter (4-bit counter with LOAD, EN, and tri-stated OE output) between `N_REQ` requesters. For each granted requester, the block:
- loads the requester's start value,
- counts for the requested number of cycles,
- drives the counter output onto the shared bus and captures it,
- returns the result with a one-cycle `done` pulse.

It sits between the requesting blocks and the counter instance, and it is the only driver of the counter's control pins.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `WIDTH`, 4, counter data width
- `LEN_W`, 4, width of a requester's count-length field
- `clk` in 1: single clock, all state on rising edge
- `rst_n` in 1: reset is asynchronous and active-low
- `req` in `N_REQ`: per-requester request level, held until `done` or withdrawn
- `load_val` in `N_REQ*WIDTH`: start value; requester i occupies bits [i*WIDTH +: WIDTH]
- `cnt_len` in `N_REQ*LEN_W`: number of count cycles; requester i occupies bits [i*LEN_W +: LEN_W]
- `gnt` out `N_REQ`: one-hot grant, all-zero when idle
- `done` out `N_REQ`: one-cycle pulse to the served requester
- `result` out `WIDTH`: captured counter value, held until the next capture
- `busy` out 1: high in every state except IDLE
- `cnt_load` out 1: drives the counter's LOAD
- `cnt_en` out 1: drives the counter's EN
- `cnt_oe` out 1: drives the counter's OE
- `cnt_d` out `WIDTH`: drives the counter's D
- `cnt_q` in `WIDTH`: shared tri-state bus, read back from the counter

## Operation
- FSM states and transitions:
  - IDLE → LOAD when any `req` bit is set.
  - LOAD → COUNT, or LOAD → READ when the granted `cnt_len` = 0.
  - COUNT → READ after `cnt_len` cycles.
  - READ → DONE.
  - DONE → IDLE.
- Arbitration happens in IDLE only.
  - Round-robin search starts at pointer `ptr`.
  - The winner is latched into a grant index for the whole transaction.
  - `ptr` advances to winner+1 (mod `N_REQ`) on entering DONE.
- LOAD (1 cycle): `cnt_load`=1, `cnt_d`=`load_val` of the winner, `cnt_en`=0.
- COUNT: `cnt_en`=1, `cnt_load`=0.
  - The `cnt_len` value is latched into an internal down-counter on entering LOAD.
  - The state is left when the down-counter reaches 1.
- READ (1 cycle): `cnt_oe`=1. `cnt_q` is sampled into `result` at the closing edge.
- DONE (1 cycle): `done[winner]`=1. `gnt` stays asserted through DONE.
- `gnt[winner]` is high from LOAD through DONE inclusive.
- Control outputs are registered Moore outputs: no combinational path from `req` to any output.
- Arithmetic: expected `result` = (`load_val` + `cnt_len`) mod 2^`WIDTH`. Wrap-around is the counter's natural overflow; the controller applies no correction.
- Withdrawal:
  - If `req[winner]` drops in LOAD or COUNT, the FSM returns to IDLE next cycle with all controls 0.
  - No `done` is issued, `result` is unchanged, and `ptr` still advances past the winner.
- Withdrawal in READ or DONE is ignored; the transaction completes.
- `cnt_oe` is high only in READ. The counter never drives the bus otherwise.
- `cnt_load` and `cnt_en` are never high in the same cycle.
- Simultaneous requests: exactly one grant per transaction. Other requesters wait; their `req` stays high.
- Inputs of the winner are only required stable from the IDLE sample to the end of LOAD. `cnt_len` is latched; `load_val` is used in LOAD.

## Timing
- Request sampled in IDLE at cycle 0 → LOAD in cycle 1, COUNT in cycles 2..L+1, READ in cycle L+2, DONE in cycle L+3, IDLE in cycle L+4 (L = `cnt_len`).
- Minimum transaction is 4 cycles (L=0). Back-to-back service adds one IDLE cycle between grants.
- `result` is valid from the DONE cycle onward.
- Reset:
  - `rst_n` low at any time, including mid-transaction, forces state IDLE, `ptr`=0, and `result`=0 immediately.
  - All outputs go to 0 immediately: `gnt`, `done`, `busy`, `cnt_load`, `cnt_en`, `cnt_oe`, `cnt_d`.
- Release is synchronous to the first `clk` rising edge after `rst_n` goes high.

## Structure
- Shared package `controlador_pkg`:
  - state encoding constants: IDLE, LOAD, COUNT, READ, DONE
  - default `WIDTH`/`LEN_W`/`N_REQ` values
  - a (`load_val` + `cnt_len`) expected-value function, shared by RTL assertions and the bench
- Sub-module `arbitro_rr`: combinational round-robin priority pick from `req` and `ptr`, producing a one-hot vector plus an index. The `ptr` register lives in the parent.
- The counter itself is instantiated outside this block. The bench instantiates it together with the controller.

## Test plan
- Single request: `req`=0001, `load_val[0]`=3, `cnt_len[0]`=5.
  - Expect `gnt`=0001 cycles 1–8 and `done[0]` in cycle 8.
  - Expect `result`=8 and `cnt_oe` high only in cycle 7.
- Wrap-around: `load_val`=14, `cnt_len`=5 → `result`=3.
- Zero length: `load_val`=9, `cnt_len`=0 → LOAD→READ directly, `done` in cycle 3, `result`=9.
- Fairness: `req`=1111 held with varied lengths → grants in order 0,1,2,3,0, each `done` matches its own expected value.
- Withdrawal: drop `req[2]` in the third COUNT cycle.
  - Expect return to IDLE the next cycle with no `done[2]` and `result` unchanged.
  - Expect requester 3 served next.
- Reset mid-COUNT: assert `rst_n`=0 → all outputs 0 immediately. After release, `req`=0010 is granted first.
